// File: rtl/mem_access_unit_if.sv
// Request/response channel between the execute stage and the load/store unit.
// The execute stage drives the master side; mem_access_unit takes the slave side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        misalign_err;

  modport master (
    output req_valid, alucode, addr, wdata,
    input  req_ready, resp_valid, resp_data, misalign_err
  );

  modport slave (
    input  req_valid, alucode, addr, wdata,
    output req_ready, resp_valid, resp_data, misalign_err
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit in front of the word-wide data RAM.
// One request at a time: loads are aligned and extended, sub-word stores use
// read-modify-write, misaligned accesses trap, and the UART address is
// diverted to a byte-wide transmit port.
module mem_access_unit #(
  parameter int          ADDR_W    = 16,
  parameter logic [31:0] UART_ADDR = 32'hf6fff070
) (
  input  logic              clk,
  input  logic              rst,
  mem_access_unit_if.slave  bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              uart_we,
  output logic [7:0]        uart_data,
  input  logic              uart_busy
);

  // Operation codes shared with the execute stage.
  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h18;
  localparam logic [5:0] ALU_SH  = 6'h19;
  localparam logic [5:0] ALU_SW  = 6'h1a;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ISSUE     = 3'd1;
  localparam logic [2:0] S_CAPTURE   = 3'd2;
  localparam logic [2:0] S_WRITE     = 3'd3;
  localparam logic [2:0] S_UART_WAIT = 3'd4;

  logic [2:0]  state;
  logic [5:0]  op_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] ram_wdata_q;
  logic        resp_valid_q;
  logic [31:0] resp_data_q;
  logic        misalign_q;

  logic        is_load;
  logic        is_store;
  logic        is_half;
  logic        is_word;
  logic        misaligned;
  logic        is_uart;
  logic        accept;

  // Sign/zero-extend the addressed lane of a RAM word.
  function automatic logic [31:0] fmt_load(input logic [5:0]  op,
                                           input logic [1:0]  lane,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{lane, 3'b000} +: 8];
    h = rd[{lane[1], 4'b0000} +: 16];
    case (op)
      ALU_LB:  fmt_load = {{24{b[7]}}, b};
      ALU_LBU: fmt_load = {24'b0, b};
      ALU_LH:  fmt_load = {{16{h[15]}}, h};
      ALU_LHU: fmt_load = {16'b0, h};
      default: fmt_load = rd;
    endcase
  endfunction

  // Replace one byte or halfword lane of the old word with store data.
  function automatic logic [31:0] merge_store(input logic        is_byte,
                                              input logic [1:0]  lane,
                                              input logic [31:0] old,
                                              input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    if (is_byte) r[{lane, 3'b000} +: 8] = wd[7:0];
    else         r[{lane[1], 4'b0000} +: 16] = wd[15:0];
    merge_store = r;
  endfunction

  assign is_load    = (op_q == ALU_LB) || (op_q == ALU_LH) || (op_q == ALU_LW) ||
                      (op_q == ALU_LBU) || (op_q == ALU_LHU);
  assign is_store   = (op_q == ALU_SB) || (op_q == ALU_SH) || (op_q == ALU_SW);
  assign is_half    = (op_q == ALU_LH) || (op_q == ALU_LHU) || (op_q == ALU_SH);
  assign is_word    = (op_q == ALU_LW) || (op_q == ALU_SW);
  assign misaligned = (is_half && addr_q[0]) || (is_word && (addr_q[1:0] != 2'b00));
  assign is_uart    = (addr_q == UART_ADDR);

  assign bus.req_ready    = (state == S_IDLE) && !rst;
  assign accept           = bus.req_valid && bus.req_ready;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_data    = resp_data_q;
  assign bus.misalign_err = misalign_q;

  // RAM and UART strobes decode straight from state so an async reset drops them at once.
  assign ram_addr  = addr_q[ADDR_W+1:2];
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ((state == S_ISSUE) && is_store && is_word && !misaligned && !is_uart) ||
                     (state == S_WRITE);
  assign uart_we   = (state == S_UART_WAIT) && !uart_busy;
  assign uart_data = wdata_q[7:0];

  // Request sequencing: latch on accept, walk the access states, pulse the response.
  // NOTE: the reset branch is in the sensitivity list, so an abandoned RMW or
  // UART transfer is cleared the moment rst rises, not at the next clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op_q         <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      ram_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees the pre-edge state;
      // these defaults make resp_valid and misalign_err single-cycle pulses.
      resp_valid_q <= 1'b0;
      misalign_q   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q        <= bus.alucode;
            addr_q      <= bus.addr;
            wdata_q     <= bus.wdata;
            ram_wdata_q <= bus.wdata;
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!is_load && !is_store) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            state        <= S_IDLE;
          end else if (misaligned) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            misalign_q   <= 1'b1;
            state        <= S_IDLE;
          end else if (is_uart) begin
            if (is_load) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= {31'b0, uart_busy};
              state        <= S_IDLE;
            end else begin
              state <= S_UART_WAIT;
            end
          end else if (is_load || !is_word) begin
            state <= S_CAPTURE;
          end else begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            state        <= S_IDLE;
          end
        end
        S_CAPTURE: begin
          if (is_load) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fmt_load(op_q, addr_q[1:0], ram_rdata);
            state        <= S_IDLE;
          end else begin
            ram_wdata_q <= merge_store(op_q == ALU_SB, addr_q[1:0], ram_rdata, wdata_q);
            state       <= S_WRITE;
          end
        end
        S_WRITE: begin
          resp_valid_q <= 1'b1;
          resp_data_q  <= '0;
          state        <= S_IDLE;
        end
        S_UART_WAIT: begin
          if (!uart_busy) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= '0;
            state        <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a RAM model and a response scoreboard.
module tb_mem_access_unit;

  localparam logic [5:0] ALU_LB  = 6'h10;
  localparam logic [5:0] ALU_LH  = 6'h11;
  localparam logic [5:0] ALU_LW  = 6'h12;
  localparam logic [5:0] ALU_LBU = 6'h13;
  localparam logic [5:0] ALU_LHU = 6'h14;
  localparam logic [5:0] ALU_SB  = 6'h18;
  localparam logic [5:0] ALU_SH  = 6'h19;
  localparam logic [5:0] ALU_SW  = 6'h1a;
  localparam logic [5:0] ALU_NOP = 6'h3f;
  localparam logic [31:0] UART   = 32'hf6fff070;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          e0;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] ram_addr;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        uart_we;
  logic [7:0]  uart_data;
  logic        uart_busy = 1'b0;

  mem_access_unit_if bus();

  mem_access_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .uart_we   (uart_we),
    .uart_data (uart_data),
    .uart_busy (uart_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM model, one-cycle read latency, plus a bench preload port.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  always @(posedge clk) begin
    if (pre_we)      mem[pre_idx] <= pre_val;
    else if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
    ram_rdata <= mem[ram_addr[7:0]];
  end

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  int   ram_we_cnt = 0;
  int   uart_we_cnt = 0;
  int   uart_cyc = -1;
  logic [7:0] uart_byte = '0;
  int   last_resp_cyc = -1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and observe the DUT there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (ram_we) ram_we_cnt++;
    if (uart_we) begin
      uart_we_cnt++;
      uart_cyc  = cyc;
      uart_byte = uart_data;
    end
    if (bus.resp_valid) begin
      last_resp_cyc = cyc;
      check("resp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("resp_data", bus.resp_data, e.data);
        check("misalign_err", 32'(bus.misalign_err), 32'(e.err));
        if (e.lat >= 0) check("resp_latency", cyc - e.e0, e.lat);
      end
    end
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] val);
    pre_idx = idx;
    pre_val = val;
    pre_we  = 1'b1;
    tick();
    pre_we  = 1'b0;
  endtask

  // Present a request at a falling edge; queue its expected response when accepted.
  task automatic issue(input logic [5:0] code, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_data, input logic exp_err, input int lat,
                       input bit push);
    bit done;
    exp_t e;
    done = 1'b0;
    bus.req_valid = 1'b1;
    bus.alucode   = code;
    bus.addr      = a;
    bus.wdata     = wd;
    for (int i = 0; i < 20 && !done; i++) begin
      if (bus.req_ready) begin
        if (push) begin
          e.data = exp_data; e.err = exp_err; e.e0 = cyc + 1; e.lat = lat;
          sb.push_back(e);
        end
        done = 1'b1;
      end
      tick();
    end
    bus.req_valid = 1'b0;
    check("req_accepted", 32'(done), 32'd1);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int we0, ue0, drop_cyc;
    bus.req_valid = 1'b0;
    bus.alucode   = '0;
    bus.addr      = '0;
    bus.wdata     = '0;

    // Reset state.
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_misalign", 32'(bus.misalign_err), 0);
    check("rst_resp_data", bus.resp_data, 0);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_uart_we", 32'(uart_we), 0);
    check("rst_uart_data", 32'(uart_data), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 1);

    preload(8'd0, 32'h01020304);
    preload(8'd4, 32'h8899AABB);

    // Loads from word 4, issued back to back.
    issue(ALU_LB,  32'h12, 0, 32'hFFFFFF99, 0, 2, 1);
    issue(ALU_LBU, 32'h12, 0, 32'h00000099, 0, 2, 1);
    issue(ALU_LH,  32'h12, 0, 32'hFFFF8899, 0, 2, 1);
    issue(ALU_LHU, 32'h10, 0, 32'h0000AABB, 0, 2, 1);
    issue(ALU_LB,  32'h13, 0, 32'hFFFFFF88, 0, 2, 1);
    issue(ALU_LBU, 32'h10, 0, 32'h000000BB, 0, 2, 1);
    issue(ALU_LW,  32'h10, 0, 32'h8899AABB, 0, 2, 1);
    wait_done();

    // Full-word store then read back.
    we0 = ram_we_cnt;
    issue(ALU_SW, 32'h20, 32'hDEADBEEF, 0, 0, 1, 1);
    wait_done();
    check("sw_we_pulses", ram_we_cnt - we0, 1);
    issue(ALU_LW, 32'h20, 0, 32'hDEADBEEF, 0, 2, 1);
    wait_done();

    // Read-modify-write byte and halfword stores into word 8.
    preload(8'd8, 32'h11223344);
    we0 = ram_we_cnt;
    issue(ALU_SB, 32'h21, 32'h000000AA, 0, 0, 3, 1);
    wait_done();
    check("sb_word", mem[8], 32'h1122AA44);
    check("sb_we_pulses", ram_we_cnt - we0, 1);
    issue(ALU_SH, 32'h22, 32'h00005566, 0, 0, 3, 1);
    wait_done();
    check("sh_word", mem[8], 32'h5566AA44);

    // Misaligned accesses and a no-op.
    we0 = ram_we_cnt;
    issue(ALU_LW,  32'h06, 0, 0, 1, 1, 1);
    issue(ALU_SH,  32'h03, 32'hFFFF, 0, 1, 1, 1);
    issue(ALU_SW,  32'h22, 32'hFFFFFFFF, 0, 1, 1, 1);
    issue(ALU_NOP, 32'h00, 32'hFFFFFFFF, 0, 0, 1, 1);
    wait_done();
    check("misalign_no_we", ram_we_cnt - we0, 0);
    check("misalign_word0", mem[0], 32'h01020304);

    // UART status load, busy and idle.
    uart_busy = 1'b1;
    issue(ALU_LW, UART, 0, 32'h1, 0, 1, 1);
    wait_done();
    uart_busy = 1'b0;
    issue(ALU_LBU, UART, 0, 32'h0, 0, 1, 1);
    wait_done();

    // UART byte store held off by busy for three cycles.
    we0 = ram_we_cnt;
    ue0 = uart_we_cnt;
    uart_busy = 1'b1;
    issue(ALU_SB, UART, 32'h00000041, 0, 0, -1, 1);
    tick();
    tick();
    check("uart_held_while_busy", uart_we_cnt - ue0, 0);
    @(posedge clk);
    #1;
    uart_busy = 1'b0;
    drop_cyc = cyc;
    wait_done();
    check("uart_we_pulses", uart_we_cnt - ue0, 1);
    check("uart_byte", 32'(uart_byte), 32'h41);
    check("uart_we_cycle", uart_cyc, drop_cyc);
    check("uart_resp_cycle", last_resp_cyc, uart_cyc + 1);
    check("uart_no_ram_we", ram_we_cnt - we0, 0);

    // Reset while an SB read-modify-write sits in CAPTURE.
    preload(8'd8, 32'h11223344);
    we0 = ram_we_cnt;
    issue(ALU_SB, 32'h21, 32'h000000AA, 0, 0, 3, 0);
    tick();
    rst = 1'b1;
    #1;
    check("midrst_ram_we", 32'(ram_we), 0);
    check("midrst_ram_wdata", ram_wdata, 0);
    check("midrst_ram_addr", 32'(ram_addr), 0);
    check("midrst_resp_valid", 32'(bus.resp_valid), 0);
    check("midrst_resp_data", bus.resp_data, 0);
    check("midrst_uart_we", 32'(uart_we), 0);
    check("midrst_ready", 32'(bus.req_ready), 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_ready", 32'(bus.req_ready), 1);
    for (int i = 0; i < 6; i++) tick();
    check("midrst_no_write", ram_we_cnt - we0, 0);
    check("midrst_word8", mem[8], 32'h11223344);

    // Unit still works after the abandoned operation.
    issue(ALU_LW, 32'h20, 0, 32'h11223344, 0, 2, 1);
    wait_done();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
